timer_arbiter: RTL

Shares one prescaled countdown timer between `N_REQ` requesters on the board design. Each requester asks for a delay in prescaler units. The block grants the timer round-robin, counts the winner's delay down, and then pulses that requester's `done`. It sits between the I/O logic (buttons, LED sequencers) and the 100 MHz system clock, so blocks no longer need their own free-running counters.

---
 rtl/timer_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one prescaled countdown timer between N_REQ requesters.
// The owner's delay is counted down in PRESCALE-cycle units, then its done output pulses for one cycle.
module timer_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned PRESCALE = 100000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] dur,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic [CNT_W-1:0]       remain
);

    localparam int unsigned PTR_W = $clog2(N_REQ);
    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state, state_nxt;
    logic [N_REQ-1:0]   grant_nxt;
    logic [N_REQ-1:0]   done_nxt;
    logic               busy_nxt;
    logic [CNT_W-1:0]   remain_nxt;
    logic [PTR_W-1:0]   ptr, ptr_nxt;
    logic [PTR_W-1:0]   owner, owner_nxt;
    logic [PRE_W-1:0]   pre, pre_nxt;
    logic [PTR_W-1:0]   win;
    logic [PTR_W-1:0]   idx;
    logic               win_found;
    logic [PTR_W-1:0]   owner_inc;

    // First pending requester at or above ptr, wrapping around
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = PTR_W'((32'(ptr) + k) % N_REQ);
            if (!win_found && req[idx]) begin
                win       = idx;
                win_found = 1'b1;
            end
        end
    end

    assign owner_inc = PTR_W'((32'(owner) + 32'd1) % N_REQ);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            grant  <= '0;
            done   <= '0;
            busy   <= 1'b0;
            remain <= '0;
            ptr    <= '0;
            owner  <= '0;
            pre    <= '0;
        end else begin
            state  <= state_nxt;
            grant  <= grant_nxt;
            done   <= done_nxt;
            busy   <= busy_nxt;
            remain <= remain_nxt;
            ptr    <= ptr_nxt;
            owner  <= owner_nxt;
            pre    <= pre_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        done_nxt   = '0;
        busy_nxt   = busy;
        remain_nxt = remain;
        ptr_nxt    = ptr;
        owner_nxt  = owner;
        pre_nxt    = pre;
        case (state)
            IDLE: begin
                if (win_found) begin
                    owner_nxt  = win;
                    grant_nxt  = N_REQ'(1) << win;
                    busy_nxt   = 1'b1;
                    remain_nxt = dur[32'(win)*CNT_W +: CNT_W];
                    pre_nxt    = '0;
                    state_nxt  = RUN;
                end
            end
            RUN: begin
                // Abort outranks expiry; expiry outranks counting, so remain never wraps
                if (!req[owner]) begin
                    grant_nxt  = '0;
                    busy_nxt   = 1'b0;
                    remain_nxt = '0;
                    ptr_nxt    = owner_inc;
                    state_nxt  = IDLE;
                end else if (remain == '0) begin
                    grant_nxt  = '0;
                    busy_nxt   = 1'b0;
                    done_nxt   = grant;
                    ptr_nxt    = owner_inc;
                    state_nxt  = DONE;
                end else if (pre == PRE_MAX) begin
                    pre_nxt    = '0;
                    remain_nxt = remain - CNT_W'(1);
                end else begin
                    pre_nxt    = pre + PRE_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
